game_sequencer: RTL and testbench

//  Central run-control FSM for the dinosaur game. Debounces the active-low jump button,

---
 rtl/game_sequencer.sv | 156 +++++++++++++++
 tb/tb_game_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Run-control for the dinosaur game: debounced start/jump button, IDLE/CLEAR/RUN/OVER
// sequencing, game-tick generation with level-based speed-up, and score/level tracking.
module game_sequencer #(
  parameter int TICK_DIV    = 50000,
  parameter int TICK_STEP   = 5000,
  parameter int LEVEL_TICKS = 256,
  parameter int MAX_LEVEL   = 7,
  parameter int DEB_CYCLES  = 20000,
  parameter int LOCK_CYCLES = 100000,
  parameter int SCORE_W     = 14,
  parameter int LEVEL_W     = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               jump,
  input  logic               collide,
  output logic               clear,
  output logic               tick,
  output logic               jump_cmd,
  output logic               running,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level
);

  localparam int TCNT_W = $clog2(TICK_DIV + 1);
  localparam int LCNT_W = $clog2(LEVEL_TICKS + 1);
  localparam int DCNT_W = $clog2(DEB_CYCLES + 1);
  localparam int KCNT_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [DCNT_W-1:0]  DEB_LAST  = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [LCNT_W-1:0]  LVL_LAST  = LCNT_W'(LEVEL_TICKS - 1);
  localparam logic [KCNT_W-1:0]  LOCK_LAST = KCNT_W'(LOCK_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, OVER} state_t;

  function automatic logic [SCORE_W-1:0] sat_score_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  function automatic logic [LEVEL_W-1:0] sat_level_inc(input logic [LEVEL_W-1:0] l);
    return (l >= LEVEL_MAX) ? l : l + 1'b1;
  endfunction

  // Terminal count of the tick counter: period shrinks by TICK_STEP per level.
  function automatic logic [TCNT_W-1:0] tick_last(input logic [LEVEL_W-1:0] l);
    int p;
    p = TICK_DIV - int'(l) * TICK_STEP - 1;
    return TCNT_W'(p);
  endfunction

  logic              sync_p0, sync_p1;
  logic              deb, press;
  logic [DCNT_W-1:0] deb_cnt;

  state_t            state, state_nx;
  logic [TCNT_W-1:0] tick_cnt;
  logic [LCNT_W-1:0] lvl_cnt;
  logic [KCNT_W-1:0] lock_cnt;
  logic              lock_done;
  logic              run_tick;

  // Stage p0/p1: synchroniser, then debounce; press fires on an accepted 1->0 change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      deb     <= 1'b1;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= jump;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (sync_p1 == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        deb     <= sync_p1;
        press   <= deb;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign lock_done = (lock_cnt == LOCK_LAST);
  assign run_tick  = (state == RUN) && !collide && (tick_cnt == tick_last(level));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (press) state_nx = CLEAR;
      CLEAR:   state_nx = RUN;
      RUN:     if (collide) state_nx = OVER;
      OVER:    if (press && lock_done) state_nx = CLEAR;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    running   = (state == RUN);
    game_over = (state == OVER);
  end

  // Stage p2: registered pulses, tick/level/lock counters, score and level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clear    <= 1'b0;
      tick     <= 1'b0;
      jump_cmd <= 1'b0;
      tick_cnt <= '0;
      lvl_cnt  <= '0;
      lock_cnt <= '0;
      score    <= '0;
      level    <= '0;
    end else begin
      clear    <= (state_nx == CLEAR);
      tick     <= run_tick;
      jump_cmd <= (state == RUN) && !collide && press;

      if (state == OVER) lock_cnt <= lock_done ? lock_cnt : lock_cnt + 1'b1;
      else               lock_cnt <= '0;

      if (state == CLEAR) begin
        score    <= '0;
        level    <= '0;
        tick_cnt <= '0;
        lvl_cnt  <= '0;
      end else if ((state == RUN) && !collide) begin
        if (run_tick) begin
          tick_cnt <= '0;
          score    <= sat_score_inc(score);
          if (lvl_cnt == LVL_LAST) begin
            lvl_cnt <= '0;
            level   <= sat_level_inc(level);
          end else begin
            lvl_cnt <= lvl_cnt + 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end else begin
        tick_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, hand-written reset/bounce sequences,
// then randomized button/collide traffic against a rule-level reference model.
module tb_game_sequencer;

  localparam int TICK_DIV    = 10;
  localparam int TICK_STEP   = 2;
  localparam int LEVEL_TICKS = 4;
  localparam int MAX_LEVEL   = 3;
  localparam int DEB_CYCLES  = 3;
  localparam int LOCK_CYCLES = 8;
  localparam int SCORE_W     = 4;
  localparam int LEVEL_W     = 3;
  localparam int SCORE_TOP   = (1 << SCORE_W) - 1;

  localparam int S_IDLE = 0, S_CLEAR = 1, S_RUN = 2, S_OVER = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               jump, collide;
  logic               clear, tick, jump_cmd, running, game_over;
  logic [SCORE_W-1:0] score;
  logic [LEVEL_W-1:0] level;

  int n_vec = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  game_sequencer #(
    .TICK_DIV(TICK_DIV), .TICK_STEP(TICK_STEP), .LEVEL_TICKS(LEVEL_TICKS),
    .MAX_LEVEL(MAX_LEVEL), .DEB_CYCLES(DEB_CYCLES), .LOCK_CYCLES(LOCK_CYCLES),
    .SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W)
  ) dut (
    .clock(clock), .reset(reset), .jump(jump), .collide(collide),
    .clear(clear), .tick(tick), .jump_cmd(jump_cmd), .running(running),
    .game_over(game_over), .score(score), .level(level)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] pk(input logic c, input logic t, input logic j,
                                     input logic r, input logic o, input int s, input int l);
    return {c, t, j, r, o, SCORE_W'(s), LEVEL_W'(l)};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {clear, tick, jump_cmd, running, game_over, score, level};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got clr,tick,jcmd,run,over=%b score=%0d level=%0d; want %b score=%0d level=%0d",
               name, act[11:7], act[6:3], act[2:0], exp[11:7], exp[6:3], exp[2:0]);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  // Reference model: game progress expressed as total ticks survived since CLEAR.
  int   m_st, m_ticks, m_since, m_over;
  logic m_s1, m_s2, m_deb, m_press, m_clr, m_tick, m_jcmd;
  logic m_win[$];

  function automatic int m_level();
    int lv;
    lv = m_ticks / LEVEL_TICKS;
    return (lv > MAX_LEVEL) ? MAX_LEVEL : lv;
  endfunction

  function automatic int m_score();
    return (m_ticks > SCORE_TOP) ? SCORE_TOP : m_ticks;
  endfunction

  function automatic logic [11:0] m_expect();
    return pk(m_clr, m_tick, m_jcmd, m_st == S_RUN, m_st == S_OVER, m_score(), m_level());
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_ticks = 0; m_since = 0; m_over = 0;
    m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b1; m_press = 1'b0;
    m_clr = 1'b0; m_tick = 1'b0; m_jcmd = 1'b0;
    m_win.delete();
  endtask

  task automatic model_edge();
    logic p, flip;
    p = m_press;
    // accept a new button level once the last DEB_CYCLES synced samples all disagree
    m_win.push_back(m_s2);
    if (m_win.size() > DEB_CYCLES) void'(m_win.pop_front());
    flip = (m_win.size() == DEB_CYCLES);
    foreach (m_win[i]) if (m_win[i] == m_deb) flip = 1'b0;
    m_press = 1'b0;
    if (flip) begin
      m_deb   = ~m_deb;
      m_press = (m_deb == 1'b0);
    end
    m_s2 = m_s1;
    m_s1 = jump;
    m_clr = 1'b0; m_tick = 1'b0; m_jcmd = 1'b0;
    case (m_st)
      S_IDLE: if (p) begin m_st = S_CLEAR; m_clr = 1'b1; end
      S_CLEAR: begin m_st = S_RUN; m_ticks = 0; m_since = 0; end
      S_RUN: begin
        if (collide) begin
          m_st = S_OVER; m_over = 0;
        end else begin
          m_jcmd = p;
          m_since++;
          if (m_since == TICK_DIV - m_level() * TICK_STEP) begin
            m_tick = 1'b1; m_ticks++; m_since = 0;
          end
        end
      end
      default: begin
        if (p && m_over == LOCK_CYCLES - 1) begin m_st = S_CLEAR; m_clr = 1'b1; end
        else if (m_over < LOCK_CYCLES - 1) m_over++;
      end
    endcase
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else if (model_on) model_edge();
  end

  typedef struct {
    logic        j;
    logic        c;
    int          n;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic j, input logic c, input int n, input logic [11:0] exp);
    vec_t v;
    v.j = j; v.c = c; v.n = n; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    jump = 1'b1;
    collide = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset", pk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    // edge counts below are measured from reset release
    add(0, 0, 5,  pk(0, 0, 0, 0, 0, 0, 0));   // 5: press just debounced
    add(0, 0, 1,  pk(1, 0, 0, 0, 0, 0, 0));   // 6: CLEAR
    add(0, 0, 1,  pk(0, 0, 0, 1, 0, 0, 0));   // 7: RUN entry
    add(0, 0, 3,  pk(0, 0, 0, 1, 0, 0, 0));   // 10: held button, no jump_cmd
    add(1, 0, 6,  pk(0, 0, 0, 1, 0, 0, 0));   // 16
    add(1, 0, 1,  pk(0, 1, 0, 1, 0, 1, 0));   // 17: first tick
    add(1, 0, 1,  pk(0, 0, 0, 1, 0, 1, 0));   // 18
    add(1, 0, 28, pk(0, 0, 0, 1, 0, 3, 0));   // 46
    add(1, 0, 1,  pk(0, 1, 0, 1, 0, 4, 1));   // 47: tick 4 -> level 1
    add(1, 0, 7,  pk(0, 0, 0, 1, 0, 4, 1));   // 54
    add(1, 0, 1,  pk(0, 1, 0, 1, 0, 5, 1));   // 55: spacing 8
    add(1, 0, 48, pk(0, 1, 0, 1, 0, 12, 3));  // 103: tick 12 -> level 3
    add(1, 0, 3,  pk(0, 0, 0, 1, 0, 12, 3));  // 106
    add(1, 0, 1,  pk(0, 1, 0, 1, 0, 13, 3));  // 107: spacing 4
    add(1, 0, 28, pk(0, 1, 0, 1, 0, 15, 3));  // 135: tick 20, score saturated
    add(1, 0, 3,  pk(0, 0, 0, 1, 0, 15, 3));  // 138
    add(1, 0, 1,  pk(0, 1, 0, 1, 0, 15, 3));  // 139: level stays 3
    add(1, 0, 2,  pk(0, 0, 0, 1, 0, 15, 3));  // 141
    add(0, 0, 1,  pk(0, 0, 0, 1, 0, 15, 3));  // 142: button goes down
    add(0, 1, 1,  pk(0, 0, 0, 0, 1, 15, 3));  // 143: collide beats tick
    add(0, 1, 4,  pk(0, 0, 0, 0, 1, 15, 3));  // 147: press during lockout dropped
    add(0, 0, 1,  pk(0, 0, 0, 0, 1, 15, 3));  // 148
    add(1, 0, 12, pk(0, 0, 0, 0, 1, 15, 3));  // 160: lockout done, released
    add(0, 0, 5,  pk(0, 0, 0, 0, 1, 15, 3));  // 165
    add(0, 0, 1,  pk(1, 0, 0, 0, 0, 15, 3));  // 166: restart CLEAR
    add(0, 0, 1,  pk(0, 0, 0, 1, 0, 0, 0));   // 167: RUN, cleared
    add(1, 0, 8,  pk(0, 0, 0, 1, 0, 0, 0));   // 175
    add(0, 0, 5,  pk(0, 0, 0, 1, 0, 1, 0));   // 180
    add(0, 0, 1,  pk(0, 0, 1, 1, 0, 1, 0));   // 181: jump_cmd
    add(1, 0, 1,  pk(0, 0, 0, 1, 0, 1, 0));   // 182
    add(1, 0, 4,  pk(0, 0, 0, 1, 0, 1, 0));   // 186
    add(1, 1, 1,  pk(0, 0, 0, 0, 1, 1, 0));   // 187: collide on tick, score kept

    for (int i = 0; i < tbl.size(); i++) begin
      jump = tbl[i].j;
      collide = tbl[i].c;
      wait_edges(tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Restart, run to score 5, then async reset mid-cycle.
    collide = 1'b0;
    jump = 1'b1;
    wait_edges(10);
    jump = 1'b0;
    wait_edges(6);
    check("restart_clear", pk(1, 0, 0, 0, 0, 1, 0));
    wait_edges(1);
    check("restart_run", pk(0, 0, 0, 1, 0, 0, 0));
    jump = 1'b1;
    wait_edges(49);
    check("score5", pk(0, 0, 0, 1, 0, 5, 1));
    #2 reset = 1'b0;
    #1 check("async_reset", pk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 1'b1;
    wait_edges(3);
    check("post_reset_idle", pk(0, 0, 0, 0, 0, 0, 0));

    // Bouncing button never qualifies as a press.
    for (int i = 0; i < 6; i++) begin
      jump = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_edges(1);
      check($sformatf("bounce%0d", i), pk(0, 0, 0, 0, 0, 0, 0));
    end
    jump = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      check($sformatf("bounce_settle%0d", i), pk(0, 0, 0, 0, 0, 0, 0));
    end

    // Randomized traffic against the reference model.
    reset = 1'b0;
    wait_edges(1);
    reset = 1'b1;
    model_on = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) jump = ~jump;
      collide = ($urandom_range(0, 39) == 0);
      wait_edges(1);
      check($sformatf("rand%0d", i), m_expect());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
